// File: rtl/udp_pkg.sv
// Shared definitions for the UDP stream decoder: FSM states, the header
// length and the byte offsets of each 16-bit header field.
package udp_pkg;

    localparam int UDP_HDR_BYTES = 8;

    // Byte offsets of the 16-bit fields within the UDP header
    localparam int SRC_PORT_OFF = 0;
    localparam int DST_PORT_OFF = 2;
    localparam int LENGTH_OFF   = 4;
    localparam int CHECKSUM_OFF = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } udp_state_t;

endpackage

// File: rtl/udp_hdr_shift.sv
// Header shift register and field latch for the UDP stream decoder.
// The shift register collects header words MSB-first; when the last header
// word arrives the fields are taken from the combined (next) header value so
// they can be latched on the same edge that accepts that word.
module udp_hdr_shift
    import udp_pkg::*;
#(
    parameter int AVL_SIZE  = 8,
    parameter int BYTE_SIZE = 8,
    parameter int HDR_BYTES = UDP_HDR_BYTES
) (
    input  logic                clk,
    input  logic                sync_reset_n,
    input  logic                load_first,
    input  logic                shift_en,
    input  logic                latch_en,
    input  logic [AVL_SIZE-1:0] data_in,
    output logic [15:0]         dst_port_next,
    output logic [15:0]         raw_length_next,
    output logic [15:0]         src_port,
    output logic [15:0]         dst_port,
    output logic [15:0]         length,
    output logic [15:0]         checksum
);

    localparam int HDR_BITS  = HDR_BYTES * BYTE_SIZE;
    localparam int SRC_MSB   = HDR_BITS - 1 - SRC_PORT_OFF * BYTE_SIZE;
    localparam int DST_MSB   = HDR_BITS - 1 - DST_PORT_OFF * BYTE_SIZE;
    localparam int LEN_MSB   = HDR_BITS - 1 - LENGTH_OFF * BYTE_SIZE;
    localparam int CSUM_MSB  = HDR_BITS - 1 - CHECKSUM_OFF * BYTE_SIZE;

    logic [HDR_BITS-1:0] hdr_reg;
    logic [HDR_BITS-1:0] hdr_next;

    // Next header value: a sop beat starts a fresh header, later beats shift in
    always_comb begin
        hdr_next = hdr_reg;
        if (load_first) begin
            hdr_next = HDR_BITS'(data_in);
        end else if (shift_en) begin
            hdr_next = (hdr_reg << AVL_SIZE) | HDR_BITS'(data_in);
        end
    end

    assign dst_port_next   = hdr_next[DST_MSB -: 16];
    assign raw_length_next = hdr_next[LEN_MSB -: 16];

    // Shift register update and field latch on the last header word
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            hdr_reg  <= '0;
            src_port <= '0;
            dst_port <= '0;
            length   <= '0;
            checksum <= '0;
        end else begin
            hdr_reg <= hdr_next;
            if (latch_en) begin
                src_port <= hdr_next[SRC_MSB -: 16];
                dst_port <= hdr_next[DST_MSB -: 16];
                length   <= hdr_next[LEN_MSB -: 16] - 16'(HDR_BYTES);
                checksum <= hdr_next[CSUM_MSB -: 16];
            end
        end
    end

endmodule

// File: rtl/udp_decode_stream.sv
// UDP datagram stream decoder: strips the header, latches its fields,
// optionally filters on destination port and forwards the payload with a
// one-cycle registered latency.
module udp_decode_stream
    import udp_pkg::*;
#(
    parameter int AVL_SIZE  = 8,
    parameter int BYTE_SIZE = 8,
    parameter int HDR_BYTES = UDP_HDR_BYTES
) (
    input  logic                clk,
    input  logic                sync_reset_n,
    input  logic                data_in_valid,
    input  logic [AVL_SIZE-1:0] data_in,
    input  logic                data_in_sop,
    input  logic                data_in_eop,
    input  logic                filter_en,
    input  logic [15:0]         filter_port,
    output logic [15:0]         src_port,
    output logic [15:0]         dst_port,
    output logic [15:0]         checksum,
    output logic [15:0]         length,
    output logic                hdr_valid,
    output logic [AVL_SIZE-1:0] payload_data,
    output logic                payload_valid,
    output logic                payload_sop,
    output logic                payload_eop,
    output logic                length_error,
    output logic                port_drop
);

    localparam int HDR_WORDS = HDR_BYTES * BYTE_SIZE / AVL_SIZE;
    localparam int CNT_W     = $clog2(HDR_WORDS + 1);

    udp_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             first_payload_reg;

    logic        last_hdr;
    logic        hdr_shift;
    logic        hdr_load;
    logic        len_ok;
    logic        port_ok;
    logic [15:0] dst_port_next;
    logic [15:0] raw_length_next;

    // A beat completes the header either as the sop beat of a one-word header
    // or as word HDR_WORDS-1 while collecting the header
    always_comb begin
        hdr_load  = data_in_valid && data_in_sop;
        hdr_shift = data_in_valid && !data_in_sop && (state_reg == HEADER);
        if (data_in_sop) begin
            last_hdr = data_in_valid && (HDR_WORDS == 1);
        end else begin
            last_hdr = hdr_shift && (cnt_reg == CNT_W'(HDR_WORDS - 1));
        end
        len_ok  = (raw_length_next >= 16'(HDR_BYTES));
        port_ok = !filter_en || (dst_port_next == filter_port);
    end

    udp_hdr_shift #(
        .AVL_SIZE  (AVL_SIZE),
        .BYTE_SIZE (BYTE_SIZE),
        .HDR_BYTES (HDR_BYTES)
    ) u_hdr_shift (
        .clk             (clk),
        .sync_reset_n    (sync_reset_n),
        .load_first      (hdr_load),
        .shift_en        (hdr_shift),
        .latch_en        (last_hdr),
        .data_in         (data_in),
        .dst_port_next   (dst_port_next),
        .raw_length_next (raw_length_next),
        .src_port        (src_port),
        .dst_port        (dst_port),
        .length          (length),
        .checksum        (checksum)
    );

    // Datagram FSM with registered pulses and payload outputs
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            first_payload_reg <= 1'b0;
            hdr_valid         <= 1'b0;
            length_error      <= 1'b0;
            port_drop         <= 1'b0;
            payload_data      <= '0;
            payload_valid     <= 1'b0;
            payload_sop       <= 1'b0;
            payload_eop       <= 1'b0;
        end else begin
            hdr_valid     <= 1'b0;
            length_error  <= 1'b0;
            port_drop     <= 1'b0;
            payload_valid <= 1'b0;
            payload_sop   <= 1'b0;
            payload_eop   <= 1'b0;

            if (data_in_valid) begin
                if (data_in_sop) begin
                    // A new datagram always restarts header collection;
                    // interrupting a live datagram counts as malformed
                    cnt_reg <= CNT_W'(1);
                    if (state_reg == HEADER || state_reg == PAYLOAD) begin
                        length_error <= 1'b1;
                    end
                    if (!last_hdr) begin
                        if (data_in_eop) begin
                            length_error <= 1'b1;
                            state_reg    <= IDLE;
                        end else begin
                            state_reg <= HEADER;
                        end
                    end
                end else begin
                    case (state_reg)
                        HEADER: begin
                            if (!last_hdr) begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                                if (data_in_eop) begin
                                    // Runt: datagram ended inside the header
                                    length_error <= 1'b1;
                                    state_reg    <= IDLE;
                                end
                            end
                        end
                        PAYLOAD: begin
                            payload_valid     <= 1'b1;
                            payload_data      <= data_in;
                            payload_sop       <= first_payload_reg;
                            payload_eop       <= data_in_eop;
                            first_payload_reg <= 1'b0;
                            if (data_in_eop) begin
                                state_reg <= IDLE;
                            end
                        end
                        DROP: begin
                            if (data_in_eop) begin
                                state_reg <= IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end

                if (last_hdr) begin
                    cnt_reg <= '0;
                    if (!len_ok) begin
                        length_error <= 1'b1;
                        state_reg    <= data_in_eop ? IDLE : DROP;
                    end else if (!port_ok) begin
                        port_drop <= 1'b1;
                        state_reg <= data_in_eop ? IDLE : DROP;
                    end else begin
                        hdr_valid         <= 1'b1;
                        first_payload_reg <= 1'b1;
                        state_reg         <= data_in_eop ? IDLE : PAYLOAD;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_decode_stream.sv
// Directed bench for udp_decode_stream: an 8-bit and a 32-bit instance,
// pulse/payload monitors and immediate-assertion checks per step.
module tb_udp_decode_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sync_reset_n;
    logic        filter_en;
    logic [15:0] filter_port;

    // 8-bit instance signals
    logic        v8, sop8, eop8;
    logic [7:0]  d8;
    logic [15:0] src8, dst8, csum8, len8;
    logic        hv8, pv8, ps8, pe8, le8, pdr8;
    logic [7:0]  pd8;

    // 32-bit instance signals
    logic        v32, sop32, eop32;
    logic [31:0] d32;
    logic [15:0] src32, dst32, csum32, len32;
    logic        hv32, pv32, ps32, pe32, le32, pdr32;
    logic [31:0] pd32;

    udp_decode_stream #(.AVL_SIZE(8), .BYTE_SIZE(8), .HDR_BYTES(8)) u8 (
        .clk(clk), .sync_reset_n(sync_reset_n),
        .data_in_valid(v8), .data_in(d8), .data_in_sop(sop8), .data_in_eop(eop8),
        .filter_en(filter_en), .filter_port(filter_port),
        .src_port(src8), .dst_port(dst8), .checksum(csum8), .length(len8),
        .hdr_valid(hv8), .payload_data(pd8), .payload_valid(pv8),
        .payload_sop(ps8), .payload_eop(pe8),
        .length_error(le8), .port_drop(pdr8)
    );

    udp_decode_stream #(.AVL_SIZE(32), .BYTE_SIZE(8), .HDR_BYTES(8)) u32 (
        .clk(clk), .sync_reset_n(sync_reset_n),
        .data_in_valid(v32), .data_in(d32), .data_in_sop(sop32), .data_in_eop(eop32),
        .filter_en(1'b0), .filter_port(16'h0000),
        .src_port(src32), .dst_port(dst32), .checksum(csum32), .length(len32),
        .hdr_valid(hv32), .payload_data(pd32), .payload_valid(pv32),
        .payload_sop(ps32), .payload_eop(pe32),
        .length_error(le32), .port_drop(pdr32)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and payload capture, sampled on the falling edge
    int          hv_cnt8 = 0, le_cnt8 = 0, pd_cnt8 = 0, pv_cnt8 = 0;
    int          hv_cnt32 = 0, le_cnt32 = 0, pv_cnt32 = 0;
    logic [7:0]  pv_data8 [0:63];
    logic        pv_sop8  [0:63];
    logic        pv_eop8  [0:63];
    int          pv_cyc8  [0:63];
    logic [31:0] pv_data32 [0:15];
    logic        pv_sop32  [0:15];
    logic        pv_eop32  [0:15];
    int          pv_cyc32  [0:15];

    always @(negedge clk) begin
        if (hv8)  hv_cnt8 <= hv_cnt8 + 1;
        if (le8)  le_cnt8 <= le_cnt8 + 1;
        if (pdr8) pd_cnt8 <= pd_cnt8 + 1;
        if (pv8) begin
            if (pv_cnt8 < 64) begin
                pv_data8[pv_cnt8] <= pd8;
                pv_sop8[pv_cnt8]  <= ps8;
                pv_eop8[pv_cnt8]  <= pe8;
                pv_cyc8[pv_cnt8]  <= cyc;
            end
            pv_cnt8 <= pv_cnt8 + 1;
        end
        if (hv32) hv_cnt32 <= hv_cnt32 + 1;
        if (le32) le_cnt32 <= le_cnt32 + 1;
        if (pv32) begin
            if (pv_cnt32 < 16) begin
                pv_data32[pv_cnt32] <= pd32;
                pv_sop32[pv_cnt32]  <= ps32;
                pv_eop32[pv_cnt32]  <= pe32;
                pv_cyc32[pv_cnt32]  <= cyc;
            end
            pv_cnt32 <= pv_cnt32 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic b8(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        v8 = 1'b1; d8 = d; sop8 = s; eop8 = e;
    endtask

    task automatic idle8(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v8 = 1'b0; sop8 = 1'b0; eop8 = 1'b0; d8 = 8'h00;
        end
    endtask

    task automatic hdr8(input logic [63:0] h, input logic eop_last);
        for (int i = 0; i < 8; i++) begin
            b8(h[63 - 8*i -: 8], i == 0, eop_last && (i == 7));
        end
    endtask

    task automatic b32(input logic [31:0] d, input logic s, input logic e);
        @(negedge clk);
        v32 = 1'b1; d32 = d; sop32 = s; eop32 = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_hv, base_le, base_pd, base_pv;
        int drv [0:7];

        sync_reset_n = 1'b0;
        filter_en = 1'b0; filter_port = 16'h0000;
        v8 = 0; sop8 = 0; eop8 = 0; d8 = 0;
        v32 = 0; sop32 = 0; eop32 = 0; d32 = 0;
        repeat (2) @(negedge clk);
        sync_reset_n = 1'b1;

        // Reset state
        chk("rst_src", 32'(src8), 0);
        chk("rst_dst", 32'(dst8), 0);
        chk("rst_len", 32'(len8), 0);
        chk("rst_csum", 32'(csum8), 0);
        chk("rst_flags", {27'd0, hv8, pv8, pe8, le8, pdr8}, 0);
        chk("rst_pdata32", pd32, 0);

        // Basic 8-bit datagram with 4 payload bytes
        base_hv = hv_cnt8; base_pv = pv_cnt8; base_le = le_cnt8;
        hdr8(64'h1234_5678_000C_ABCD, 1'b0);
        for (int i = 0; i < 4; i++) begin
            b8(8'(8'hA1 + i), 1'b0, i == 3);
            drv[i] = cyc;
        end
        idle8(3);
        chk("t1_hdr_valid_cnt", 32'(hv_cnt8 - base_hv), 1);
        chk("t1_src", 32'(src8), 32'h1234);
        chk("t1_dst", 32'(dst8), 32'h5678);
        chk("t1_len", 32'(len8), 4);
        chk("t1_csum", 32'(csum8), 32'hABCD);
        chk("t1_pv_cnt", 32'(pv_cnt8 - base_pv), 4);
        chk("t1_lerr_cnt", 32'(le_cnt8 - base_le), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_pdata", 32'(pv_data8[base_pv + i]), 32'(8'hA1 + i));
            chk("t1_psop", 32'(pv_sop8[base_pv + i]), 32'(i == 0));
            chk("t1_peop", 32'(pv_eop8[base_pv + i]), 32'(i == 3));
            chk("t1_latency", 32'(pv_cyc8[base_pv + i]), 32'(drv[i] + 1));
        end

        // Port filter: mismatched destination dropped, matching one passes
        filter_en = 1'b1; filter_port = 16'h1111;
        base_hv = hv_cnt8; base_pv = pv_cnt8; base_pd = pd_cnt8;
        hdr8(64'h1234_5678_000C_ABCD, 1'b0);
        for (int i = 0; i < 4; i++) b8(8'hB0, 1'b0, i == 3);
        idle8(3);
        chk("t2_port_drop_cnt", 32'(pd_cnt8 - base_pd), 1);
        chk("t2_drop_pv_cnt", 32'(pv_cnt8 - base_pv), 0);
        chk("t2_drop_hv_cnt", 32'(hv_cnt8 - base_hv), 0);
        base_hv = hv_cnt8; base_pv = pv_cnt8; base_pd = pd_cnt8;
        hdr8(64'h2222_1111_000A_0000, 1'b0);
        b8(8'hB1, 1'b0, 1'b0);
        b8(8'hB2, 1'b0, 1'b1);
        idle8(3);
        chk("t2_pass_hv_cnt", 32'(hv_cnt8 - base_hv), 1);
        chk("t2_pass_pd_cnt", 32'(pd_cnt8 - base_pd), 0);
        chk("t2_pass_pv_cnt", 32'(pv_cnt8 - base_pv), 2);
        chk("t2_pass_src", 32'(src8), 32'h2222);
        chk("t2_pass_dst", 32'(dst8), 32'h1111);
        chk("t2_pass_len", 32'(len8), 2);
        chk("t2_pass_data1", 32'(pv_data8[base_pv + 1]), 32'hB2);
        filter_en = 1'b0;

        // Runt: eop inside the header; stray non-sop beat afterwards
        base_hv = hv_cnt8; base_pv = pv_cnt8; base_le = le_cnt8;
        b8(8'h99, 1'b1, 1'b0);
        b8(8'h99, 1'b0, 1'b0);
        b8(8'h88, 1'b0, 1'b0);
        b8(8'h88, 1'b0, 1'b0);
        b8(8'h00, 1'b0, 1'b0);
        b8(8'h10, 1'b0, 1'b1);
        b8(8'h55, 1'b0, 1'b0);
        idle8(3);
        chk("t3_runt_lerr_cnt", 32'(le_cnt8 - base_le), 1);
        chk("t3_runt_hv_cnt", 32'(hv_cnt8 - base_hv), 0);
        chk("t3_runt_pv_cnt", 32'(pv_cnt8 - base_pv), 0);
        chk("t3_runt_src_kept", 32'(src8), 32'h2222);
        chk("t3_runt_dst_kept", 32'(dst8), 32'h1111);
        chk("t3_runt_len_kept", 32'(len8), 2);

        // Raw length below header size
        base_hv = hv_cnt8; base_pv = pv_cnt8; base_le = le_cnt8;
        hdr8(64'h0102_0304_0004_0000, 1'b0);
        b8(8'hC1, 1'b0, 1'b0);
        b8(8'hC2, 1'b0, 1'b1);
        idle8(3);
        chk("t4_short_lerr_cnt", 32'(le_cnt8 - base_le), 1);
        chk("t4_short_pv_cnt", 32'(pv_cnt8 - base_pv), 0);
        chk("t4_short_hv_cnt", 32'(hv_cnt8 - base_hv), 0);

        // sop in the middle of a payload aborts and restarts decoding
        base_hv = hv_cnt8; base_pv = pv_cnt8; base_le = le_cnt8;
        hdr8(64'h1234_5678_000C_ABCD, 1'b0);
        b8(8'hD1, 1'b0, 1'b0);
        b8(8'hD2, 1'b0, 1'b0);
        hdr8(64'hAAAA_BBBB_0009_1234, 1'b0);
        b8(8'hE1, 1'b0, 1'b1);
        idle8(3);
        chk("t5_abort_lerr_cnt", 32'(le_cnt8 - base_le), 1);
        chk("t5_abort_hv_cnt", 32'(hv_cnt8 - base_hv), 2);
        chk("t5_abort_pv_cnt", 32'(pv_cnt8 - base_pv), 3);
        chk("t5_abort_no_eop0", 32'(pv_eop8[base_pv]), 0);
        chk("t5_abort_no_eop1", 32'(pv_eop8[base_pv + 1]), 0);
        chk("t5_new_data", 32'(pv_data8[base_pv + 2]), 32'hE1);
        chk("t5_new_sop", 32'(pv_sop8[base_pv + 2]), 1);
        chk("t5_new_eop", 32'(pv_eop8[base_pv + 2]), 1);
        chk("t5_new_src", 32'(src8), 32'hAAAA);
        chk("t5_new_dst", 32'(dst8), 32'hBBBB);
        chk("t5_new_len", 32'(len8), 1);
        chk("t5_new_csum", 32'(csum8), 32'h1234);

        // Reset mid-header, then an empty-payload datagram
        b8(8'h12, 1'b1, 1'b0);
        b8(8'h34, 1'b0, 1'b0);
        b8(8'h56, 1'b0, 1'b0);
        @(negedge clk);
        v8 = 1'b0; sop8 = 1'b0; eop8 = 1'b0;
        sync_reset_n = 1'b0;
        @(negedge clk);
        sync_reset_n = 1'b1;
        chk("t6_rst_src", 32'(src8), 0);
        chk("t6_rst_dst", 32'(dst8), 0);
        chk("t6_rst_len", 32'(len8), 0);
        chk("t6_rst_csum", 32'(csum8), 0);
        chk("t6_rst_flags", {27'd0, hv8, pv8, pe8, le8, pdr8}, 0);
        base_hv = hv_cnt8; base_pv = pv_cnt8; base_le = le_cnt8;
        hdr8(64'h0F0F_F0F0_0008_55AA, 1'b1);
        b8(8'h77, 1'b0, 1'b0);
        idle8(3);
        chk("t6_empty_hv_cnt", 32'(hv_cnt8 - base_hv), 1);
        chk("t6_empty_pv_cnt", 32'(pv_cnt8 - base_pv), 0);
        chk("t6_empty_lerr_cnt", 32'(le_cnt8 - base_le), 0);
        chk("t6_src", 32'(src8), 32'h0F0F);
        chk("t6_dst", 32'(dst8), 32'hF0F0);
        chk("t6_len", 32'(len8), 0);
        chk("t6_csum", 32'(csum8), 32'h55AA);

        // 32-bit instance: same datagram as three beats
        base_hv = hv_cnt32; base_pv = pv_cnt32; base_le = le_cnt32;
        b32(32'h1234_5678, 1'b1, 1'b0);
        b32(32'h000C_ABCD, 1'b0, 1'b0);
        b32(32'hA1A2_A3A4, 1'b0, 1'b1);
        drv[0] = cyc;
        @(negedge clk);
        v32 = 1'b0; sop32 = 1'b0; eop32 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7_hv_cnt", 32'(hv_cnt32 - base_hv), 1);
        chk("t7_lerr_cnt", 32'(le_cnt32 - base_le), 0);
        chk("t7_src", 32'(src32), 32'h1234);
        chk("t7_dst", 32'(dst32), 32'h5678);
        chk("t7_len", 32'(len32), 4);
        chk("t7_csum", 32'(csum32), 32'hABCD);
        chk("t7_pv_cnt", 32'(pv_cnt32 - base_pv), 1);
        chk("t7_pdata", pv_data32[base_pv], 32'hA1A2_A3A4);
        chk("t7_psop", 32'(pv_sop32[base_pv]), 1);
        chk("t7_peop", 32'(pv_eop32[base_pv]), 1);
        chk("t7_latency", 32'(pv_cyc32[base_pv]), 32'(drv[0] + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_decode_stream.md
UDP_DECODE_STREAM -- requirements
Module: udp_decode_stream

Interface
REQ-001 Parameter AVL_SIZE, default 8, meaning: datapath width in bits; legal values 8, 16, 32.
REQ-002 Parameter BYTE_SIZE, default 8, meaning: bits per byte.
REQ-003 Parameter HDR_BYTES, default 8, meaning: UDP header length in bytes; HDR_WORDS = HDR_BYTES*BYTE_SIZE/AVL_SIZE.
REQ-004 clk  input  1  sole clock; all logic is rising-edge.
REQ-005 sync_reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 data_in_valid  input  1  input beat qualifier.
REQ-007 data_in  input  AVL_SIZE  input beat, first byte in MSBs.
REQ-008 data_in_sop / data_in_eop  input  1 each  first / last beat of the datagram, valid only with data_in_valid.
REQ-009 filter_en  input  1  enables destination-port filtering.
REQ-010 filter_port  input  16  accepted destination port.
REQ-011 src_port, dst_port, checksum  output  16 each  latched header fields.
REQ-012 length  output  16  UDP length field minus HDR_BYTES.
REQ-013 hdr_valid  output  1  one-cycle pulse when the header fields are updated.
REQ-014 payload_data  output  AVL_SIZE  payload beat.
REQ-015 payload_valid / payload_sop / payload_eop  output  1 each  payload beat qualifiers.
REQ-016 length_error  output  1  one-cycle pulse on a malformed datagram.
REQ-017 port_drop  output  1  one-cycle pulse when a datagram is filtered out.

Function
REQ-018 The FSM SHALL have the states IDLE, HEADER, PAYLOAD and DROP; beats without data_in_valid are ignored in every state.
REQ-019 In any state, a valid beat with sop SHALL load it as header word 0, clear the word counter to 1 and enter HEADER (or PAYLOAD directly when HDR_WORDS=1).
REQ-020 A sop arriving in HEADER or PAYLOAD SHALL additionally pulse length_error, and no payload_eop SHALL be emitted for the aborted datagram.
REQ-021 In HEADER, each valid beat SHALL shift into the header register, MSB-first, and increment the counter.
REQ-022 On header word HDR_WORDS-1 the block SHALL latch src_port (bytes 0-1), dst_port (2-3), raw length (4-5) and checksum (6-7).
REQ-023 On that same beat, length SHALL be computed as raw length minus HDR_BYTES, modulo 2^16.
REQ-024 hdr_valid SHALL pulse in the cycle after the last header beat is accepted.
REQ-025 After the header, when raw length < HDR_BYTES, the block SHALL pulse length_error and enter DROP.
REQ-026 Otherwise, when filter_en=1 and the dst_port field differs from filter_port, the block SHALL pulse port_drop and enter DROP.
REQ-027 Otherwise the block SHALL enter PAYLOAD.
REQ-028 An eop on the last header beat SHALL give an empty payload: hdr_valid still pulses, no payload beat is emitted, and the FSM returns to IDLE.
REQ-029 An eop in HEADER before the last header word SHALL be treated as a runt: pulse length_error, return to IDLE, and leave the header outputs unchanged.
REQ-030 In PAYLOAD, each valid beat SHALL appear on payload_data with payload_valid exactly one cycle later.
REQ-031 payload_sop SHALL be asserted on the first payload beat of each datagram, and payload_eop SHALL mirror data_in_eop.
REQ-032 In PAYLOAD, a beat with eop SHALL return the FSM to IDLE.
REQ-033 DROP SHALL discard beats without emitting them and return to IDLE on eop.
REQ-034 In IDLE, valid beats without sop SHALL be discarded silently.
REQ-035 Header outputs SHALL hold their values until the next complete header.
REQ-036 length_error, port_drop and hdr_valid SHALL each be single-cycle pulses, mutually exclusive per datagram except as stated in REQ-020.

Reset
REQ-037 While sync_reset_n=0 at a clock edge, the FSM SHALL enter IDLE and the counter, header register and all outputs SHALL be set to 0.
REQ-038 A reset asserted mid-datagram SHALL abort it with no pulse or eop emitted, and the block SHALL await the next sop.

Structure
REQ-039 A shared package udp_pkg SHALL hold the FSM state typedef, UDP_HDR_BYTES=8 and the field byte offsets.
REQ-040 The header shift/latch logic SHALL be one sub-module, udp_hdr_shift, parametrised by AVL_SIZE and HDR_BYTES.
REQ-041 Everything else SHALL be flat in udp_decode_stream.

Verification
REQ-042 With AVL_SIZE=8 and filter_en=0, send header 1234 5678 000C ABCD plus 4 payload bytes -> hdr_valid pulses once; src_port=0x1234, dst_port=0x5678, length=4, checksum=0xABCD; 4 payload beats with sop on the first and eop on the last, each one cycle after input.
REQ-043 With AVL_SIZE=32, send the same datagram as 3 beats -> identical fields; one payload beat carrying sop and eop.
REQ-044 With filter_en=1 and filter_port=0x1111, send dst_port 0x5678 -> port_drop pulses and no payload_valid; a following datagram to 0x1111 passes.
REQ-045 Send raw length 0x0004 -> length_error pulses and the payload is dropped; send eop on header byte 5 -> runt, length_error pulses, and the fields keep their previous values.
REQ-046 Send a sop mid-payload -> length_error pulses and the new header decodes correctly; assert sync_reset_n=0 mid-header -> all outputs are 0 and the next datagram decodes correctly.
